pipeline_hazard_controller: RTL and testbench

Sequences the 5-stage pipeline around the forwarding unit by deciding each cycle whether the front end advances, stalls or is flushed.
- Inserts one bubble for load-use hazards that forwarding cannot cover.
- Flushes IF/ID and ID/EX on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access waits on its ready handshake.
- Keeps a saturating stall-cycle statistic and a memory-timeout error flag.

---
 rtl/pipeline_hazard_controller_if.sv | 38 +++
 rtl/pipeline_hazard_controller.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, memory handshake and pipeline control outputs.
// The controller takes the slave side; the pipeline (or testbench) takes the master side.
interface pipeline_hazard_controller_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] IFID_Rs;
  logic [REG_W-1:0] IFID_Rt;
  logic             IFID_UsesRt;
  logic             IFID_IsMem;
  logic [REG_W-1:0] IDEX_Rd;
  logic             IDEX_MemRead;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             PipeFreeze;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsMem, IDEX_Rd, IDEX_MemRead,
           EX_BranchTaken, MEM_Req, MEM_Ready,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze,
           MemTimeout, StallCount
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsMem, IDEX_Rd, IDEX_MemRead,
           EX_BranchTaken, MEM_Req, MEM_Ready,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze,
           MemTimeout, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Decides each cycle whether the 5-stage front end advances, stalls (load-use), is flushed
// (taken branch) or the whole pipe freezes on a data-memory wait; keeps stall and timeout stats.
module pipeline_hazard_controller #(
  parameter int REG_W       = 4,
  parameter int SP_REG      = 10,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rest,
  pipeline_hazard_controller_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic pc_write_s, ifid_write_s, idex_bubble_s, ifid_flush_s, idex_flush_s, pipe_freeze_s;
  logic lu_s, mw_s;

  function automatic logic load_use(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rt,
    input logic             is_mem
  );
    logic hit;
    hit = (rd == rs) || (uses_rt && (rd == rt)) || (is_mem && (rd == REG_W'(SP_REG)));
    return mem_read && (rd != {REG_W{1'b0}}) && hit;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign lu_s = load_use(hz.IDEX_MemRead, hz.IDEX_Rd, hz.IFID_Rs, hz.IFID_Rt,
                         hz.IFID_UsesRt, hz.IFID_IsMem);
  assign mw_s = hz.MEM_Req & ~hz.MEM_Ready;

  // Control outputs and next-state; branch outranks load-use, memory wait outranks both.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    pipe_freeze_s = 1'b0;
    if (rest) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
      state_d       = RUN;
      wait_cnt_d    = {WAIT_W{1'b0}};
      mem_timeout_d = 1'b0;
    end else begin
      case (state_q)
        RUN, LOAD_STALL: begin
          if (mw_s) begin
            pipe_freeze_s = 1'b1;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            state_d       = MEM_WAIT;
            wait_cnt_d    = WAIT_W'(1);
          end else if (hz.EX_BranchTaken) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            state_d       = RUN;
          end else if (lu_s && (state_q == RUN)) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            state_d       = LOAD_STALL;
          end else begin
            state_d       = RUN;
          end
        end
        MEM_WAIT: begin
          if (!hz.MEM_Ready) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
              // Give up on the access: release the pipe and flag it.
              mem_timeout_d = 1'b1;
              state_d       = RUN;
              wait_cnt_d    = {WAIT_W{1'b0}};
            end else begin
              pipe_freeze_s = 1'b1;
              pc_write_s    = 1'b0;
              ifid_write_s  = 1'b0;
              wait_cnt_d    = wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
            if (hz.EX_BranchTaken) begin
              ifid_flush_s  = 1'b1;
              idex_flush_s  = 1'b1;
              state_d       = RUN;
            end else if (lu_s) begin
              pc_write_s    = 1'b0;
              ifid_write_s  = 1'b0;
              idex_bubble_s = 1'b1;
              state_d       = LOAD_STALL;
            end else begin
              state_d       = RUN;
            end
          end
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Stall statistic: every cycle the PC is held counts, saturating at all-ones.
  always_comb begin
    if (!pc_write_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, wait counter, timeout flag and stall counter registers.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q       <= RUN;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign hz.PCWrite    = pc_write_s;
  assign hz.IFIDWrite  = ifid_write_s;
  assign hz.IDEXBubble = idex_bubble_s;
  assign hz.IFIDFlush  = ifid_flush_s;
  assign hz.IDEXFlush  = idex_flush_s;
  assign hz.PipeFreeze = pipe_freeze_s;
  assign hz.MemTimeout = mem_timeout_q;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller with a short memory timeout and a
// narrow stall counter so that timeout and saturation are reachable quickly.
module tb_pipeline_hazard_controller;
  localparam int REG_W       = 4;
  localparam int SP_REG      = 10;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Control vector order: {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze}
  localparam logic [5:0] C_RESET  = 6'b001000;
  localparam logic [5:0] C_DEF    = 6'b110000;
  localparam logic [5:0] C_BUBBLE = 6'b001000;
  localparam logic [5:0] C_FLUSH  = 6'b110110;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  logic clk;
  logic rest;
  int   n_assert;
  int   n_fail;
  logic [5:0] ctrl_s;

  pipeline_hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(
    .REG_W(REG_W), .SP_REG(SP_REG), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rest (rest),
    .hz   (bus)
  );

  assign ctrl_s = {bus.PCWrite, bus.IFIDWrite, bus.IDEXBubble,
                   bus.IFIDFlush, bus.IDEXFlush, bus.PipeFreeze};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IFID_Rs        = 4'd0;
    bus.IFID_Rt        = 4'd0;
    bus.IFID_UsesRt    = 1'b0;
    bus.IFID_IsMem     = 1'b0;
    bus.IDEX_Rd        = 4'd0;
    bus.IDEX_MemRead   = 1'b0;
    bus.EX_BranchTaken = 1'b0;
    bus.MEM_Req        = 1'b0;
    bus.MEM_Ready      = 1'b0;
    #1;
  endtask

  task automatic set_lu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                        input logic uses_rt, input logic is_mem);
    bus.IDEX_MemRead = 1'b1;
    bus.IDEX_Rd      = rd;
    bus.IFID_Rs      = rs;
    bus.IFID_Rt      = rt;
    bus.IFID_UsesRt  = uses_rt;
    bus.IFID_IsMem   = is_mem;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rest     = 1'b1;
    idle();
    #10;
    chk("reset_ctrl", 16'(ctrl_s), 16'(C_RESET));
    chk("reset_cnt", 16'(bus.StallCount), 16'd0);
    chk("reset_tmo", 16'(bus.MemTimeout), 16'd0);
    rest = 1'b0;
    tick();
    chk("idle_ctrl", 16'(ctrl_s), 16'(C_DEF));

    // Load-use on Rs: one bubble, then LOAD_STALL gives defaults with the same inputs
    set_lu(4'd5, 4'd5, 4'd0, 1'b0, 1'b0);
    chk("lu_rs_bubble", 16'(ctrl_s), 16'(C_BUBBLE));
    tick();
    chk("lu_stall_defaults", 16'(ctrl_s), 16'(C_DEF));
    chk("lu_cnt1", 16'(bus.StallCount), 16'd1);
    tick();
    idle();
    chk("after_lu_ctrl", 16'(ctrl_s), 16'(C_DEF));

    // r0 never hazards; Rt only counts when used
    set_lu(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk("r0_no_stall", 16'(ctrl_s), 16'(C_DEF));
    set_lu(4'd7, 4'd1, 4'd7, 1'b0, 1'b0);
    chk("rt_unused_no_stall", 16'(ctrl_s), 16'(C_DEF));
    set_lu(4'd10, 4'd3, 4'd0, 1'b0, 1'b0);
    chk("sp_not_mem_no_stall", 16'(ctrl_s), 16'(C_DEF));
    bus.IDEX_MemRead = 1'b0;
    bus.IDEX_Rd = 4'd5; bus.IFID_Rs = 4'd5;
    #1;
    chk("no_memread_no_stall", 16'(ctrl_s), 16'(C_DEF));
    set_lu(4'd7, 4'd1, 4'd7, 1'b1, 1'b0);
    chk("lu_rt_bubble", 16'(ctrl_s), 16'(C_BUBBLE));
    tick();
    idle();
    chk("lu_rt_cnt2", 16'(bus.StallCount), 16'd2);
    tick();
    set_lu(4'd10, 4'd3, 4'd0, 1'b0, 1'b1);
    chk("lu_sp_bubble", 16'(ctrl_s), 16'(C_BUBBLE));
    tick();
    idle();
    chk("lu_sp_stall_defaults", 16'(ctrl_s), 16'(C_DEF));
    chk("lu_sp_cnt3", 16'(bus.StallCount), 16'd3);
    tick();

    // Branch outranks load-use; state stays RUN so lu bubbles next cycle
    set_lu(4'd5, 4'd5, 4'd0, 1'b0, 1'b0);
    bus.EX_BranchTaken = 1'b1;
    #1;
    chk("branch_over_lu", 16'(ctrl_s), 16'(C_FLUSH));
    tick();
    chk("branch_cnt3", 16'(bus.StallCount), 16'd3);
    bus.EX_BranchTaken = 1'b0;
    #1;
    chk("after_branch_run_lu", 16'(ctrl_s), 16'(C_BUBBLE));
    tick();
    idle();
    tick();
    chk("after_branch_cnt4", 16'(bus.StallCount), 16'd4);

    // Memory wait of 3 cycles, branch held during the wait acts on the ready cycle
    bus.MEM_Req = 1'b1;
    #1;
    chk("mw_freeze1", 16'(ctrl_s), 16'(C_FREEZE));
    tick();
    bus.EX_BranchTaken = 1'b1;
    #1;
    chk("mw_freeze2_branch_ignored", 16'(ctrl_s), 16'(C_FREEZE));
    tick();
    chk("mw_freeze3", 16'(ctrl_s), 16'(C_FREEZE));
    tick();
    bus.MEM_Ready = 1'b1;
    #1;
    chk("mw_ready_flush", 16'(ctrl_s), 16'(C_FLUSH));
    chk("mw_cnt7", 16'(bus.StallCount), 16'd7);
    tick();
    idle();
    chk("after_mw_ctrl", 16'(ctrl_s), 16'(C_DEF));
    chk("after_mw_cnt7", 16'(bus.StallCount), 16'd7);

    // Timeout: four frozen cycles, released on the fifth, flag sticky
    bus.MEM_Req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_freeze", 16'(ctrl_s), 16'(C_FREEZE));
      tick();
    end
    chk("tmo_not_yet", 16'(bus.MemTimeout), 16'd0);
    chk("tmo_release", 16'(ctrl_s), 16'(C_DEF));
    tick();
    idle();
    chk("tmo_flag", 16'(bus.MemTimeout), 16'd1);
    chk("tmo_run_ctrl", 16'(ctrl_s), 16'(C_DEF));
    chk("tmo_cnt11", 16'(bus.StallCount), 16'd11);
    tick();
    chk("tmo_sticky", 16'(bus.MemTimeout), 16'd1);

    // Saturation: 4 frozen, 1 release, 2 more frozen -> count pinned at 15
    bus.MEM_Req = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) tick();
    chk("sat_cnt15", 16'(bus.StallCount), 16'd15);
    chk("sat_in_wait_freeze", 16'(ctrl_s), 16'(C_FREEZE));

    // Asynchronous reset in the middle of MEM_WAIT
    #2;
    rest = 1'b1;
    #1;
    chk("areset_ctrl", 16'(ctrl_s), 16'(C_RESET));
    chk("areset_cnt", 16'(bus.StallCount), 16'd0);
    chk("areset_tmo", 16'(bus.MemTimeout), 16'd0);
    rest = 1'b0;
    idle();
    chk("post_reset_run", 16'(ctrl_s), 16'(C_DEF));
    tick();
    chk("post_reset_run2", 16'(ctrl_s), 16'(C_DEF));
    chk("post_reset_cnt", 16'(bus.StallCount), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
